// File: rtl/ru_pkg.sv
// rtl/ru_pkg.sv - shared routing-unit port constants and types
package ru_pkg;

    localparam int RU_PORT_NUM = 2;
    localparam int RU_PORT_LOG = 1;

    typedef logic [RU_PORT_LOG-1:0] ru_port_t;

endpackage

// File: rtl/ru_rr_arb2.sv
// rtl/ru_rr_arb2.sv - two-requester round-robin arbiter owning the priority pointer
module ru_rr_arb2
    import ru_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RU_PORT_NUM-1:0] req,
    input  logic                   advance,
    input  ru_port_t               advance_port,
    output logic [RU_PORT_NUM-1:0] grant,
    output ru_port_t               prio
);

    ru_port_t prio_q;
    ru_port_t prio_d;

    // Priority only moves when a granted transfer completes; it points away from the winner.
    always_comb begin
        prio_d = prio_q;
        if (advance) begin
            prio_d = ~advance_port;
        end
    end

    // Priority register, port 0 favoured out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Contention resolved by prio; a lone requester always wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (prio_q == 1'b1) ? 2'b10 : 2'b01;
        end
    end

    assign prio = prio_q;

endmodule

// File: rtl/ru_merge_2to1.sv
// rtl/ru_merge_2to1.sv - round-robin merge of two port streams into one registered, port-tagged stream
module ru_merge_2to1
    import ru_pkg::*;
#(
    parameter int RU_FIFO_WIDTH = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [RU_PORT_NUM-1:0]             in_valid,
    input  logic [RU_PORT_NUM*RU_FIFO_WIDTH-1:0] in_data,
    output logic [RU_PORT_NUM-1:0]             in_ready,
    output logic                               out_valid,
    output logic [RU_FIFO_WIDTH-1:0]           out_data,
    output ru_port_t                           out_port,
    input  logic                               out_ready,
    input  logic                               cnt_clr,
    output logic [RU_PORT_NUM*CNT_WIDTH-1:0]   beat_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                     out_valid_q, out_valid_d;
    logic [RU_FIFO_WIDTH-1:0] out_data_q,  out_data_d;
    ru_port_t                 out_port_q,  out_port_d;
    logic [CNT_WIDTH-1:0]     cnt_q [RU_PORT_NUM];
    logic [CNT_WIDTH-1:0]     cnt_d [RU_PORT_NUM];

    logic [RU_PORT_NUM-1:0]   grant;
    logic [RU_PORT_NUM-1:0]   acc_vec;
    logic                     load_ok;
    logic                     accept;
    ru_port_t                 acc_port;
    ru_port_t                 prio_unused;

    ru_rr_arb2 u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (in_valid),
        .advance      (accept),
        .advance_port (acc_port),
        .grant        (grant),
        .prio         (prio_unused)
    );

    // The slot can take a beat when empty or when its current beat leaves this cycle.
    always_comb begin
        load_ok  = ~out_valid_q | out_ready;
        in_ready = (load_ok && !rst) ? grant : '0;
        acc_vec  = in_valid & in_ready;
        accept   = |acc_vec;
        acc_port = ru_port_t'(acc_vec[1]);
    end

    // Output slot next state: load on accept, drain on downstream take, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_vec[1] ? in_data[2*RU_FIFO_WIDTH-1:RU_FIFO_WIDTH]
                                     : in_data[RU_FIFO_WIDTH-1:0];
            out_port_d  = acc_port;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slot register; a held beat is simply dropped by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
        end
    end

    // Per-port saturating beat counters; clear wins over a same-cycle increment.
    always_comb begin
        for (int i = 0; i < RU_PORT_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (acc_vec[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RU_PORT_NUM; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pack counters onto the readout bus.
    always_comb begin
        for (int i = 0; i < RU_PORT_NUM; i++) begin
            beat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

endmodule
